// File: rtl/exc_ctrl.sv
// exc_ctrl: prioritises EX-stage exceptions and hardware interrupts into one trap request to CP0.
// Latency: detection edge to trap_req = 1 cycle; trap_ack to redirect = 1 cycle.
// Backpressure: trap_req/stall held with stable code/EPC until trap_ack; new events ignored meanwhile.
// Optional: define EXC_INT_SYNC_EN to pass hw_int through a 2-flop synchronizer (+2 cycles).
module exc_ctrl #(
  parameter logic [31:0] VECTOR    = 32'h0000_3000,
  parameter int          INT_LINES = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INT_LINES-1:0] hw_int,
  input  logic [INT_LINES-1:0] int_mask,
  input  logic                 int_en,
  input  logic                 exl,
  input  logic [INT_LINES-1:0] int_clr,
  input  logic                 exc_valid,
  input  logic                 exc_ri,
  input  logic                 exc_ov,
  input  logic                 exc_sys,
  input  logic                 exc_brk,
  input  logic [31:0]          exc_pc,
  input  logic [31:0]          next_pc,
  input  logic                 eret,
  output logic                 trap_req,
  output logic [4:0]           trap_code,
  output logic [31:0]          trap_epc,
  output logic                 trap_nested,
  input  logic                 trap_ack,
  output logic [INT_LINES-1:0] ip_pending,
  output logic                 flush,
  output logic                 stall,
  output logic                 redirect,
  output logic [31:0]          handler_pc,
  output logic                 in_handler
);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             code_q, code_d;
  logic [31:0]            epc_q, epc_d;
  logic                   nested_q, nested_d;
  logic                   flush_q, flush_d;
  logic                   redirect_q, redirect_d;
  logic [INT_LINES-1:0]   hw_prev_q;
  logic [INT_LINES-1:0]   ip_q, ip_d;
  logic [INT_LINES-1:0]   hw_s;
  logic                   exc_any;
  logic [4:0]             exc_code;
  logic                   int_elig;

`ifdef EXC_INT_SYNC_EN
  logic [INT_LINES-1:0]   sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
    end
  end

  assign hw_s = sync2_q;
`else
  // Lines are assumed synchronous to clk and sampled directly.
  assign hw_s = hw_int;
`endif

  // Pending bits: rising edge sets, int_clr clears, set wins on collision.
  assign ip_d = (ip_q & ~int_clr) | (hw_s & ~hw_prev_q);

  // RI > Ov > Sys > Brk; only meaningful when exc_any is set.
  assign exc_any  = exc_valid & (exc_ri | exc_ov | exc_sys | exc_brk);
  assign exc_code = exc_ri  ? 5'd10 :
                    exc_ov  ? 5'd12 :
                    exc_sys ? 5'd8  : 5'd9;
  assign int_elig = int_en & ~exl & (|(ip_q & int_mask));

  // Next-state logic: trap selection, hold while requesting, nested traps keep the original EPC.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    epc_d      = epc_q;
    nested_d   = nested_q;
    flush_d    = 1'b0;
    redirect_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d  = REQ;
          code_d   = exc_code;
          epc_d    = exc_pc;
          nested_d = 1'b0;
          flush_d  = 1'b1;
        end else if (int_elig) begin
          state_d  = REQ;
          code_d   = 5'd0;
          epc_d    = next_pc;
          nested_d = 1'b0;
          flush_d  = 1'b1;
        end
      end
      REQ: begin
        if (trap_ack) begin
          state_d    = HANDLER;
          redirect_d = 1'b1;
        end
      end
      HANDLER: begin
        // An exception in the handler beats a simultaneous eret.
        if (exc_any) begin
          state_d  = REQ;
          code_d   = exc_code;
          nested_d = 1'b1;
          flush_d  = 1'b1;
        end else if (eret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, trap payload, pulses and interrupt edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      code_q     <= 5'd0;
      epc_q      <= 32'd0;
      nested_q   <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      hw_prev_q  <= '0;
      ip_q       <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      nested_q   <= nested_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      hw_prev_q  <= hw_s;
      ip_q       <= ip_d;
    end
  end

  assign trap_req    = (state_q == REQ);
  assign stall       = (state_q == REQ);
  assign in_handler  = (state_q == HANDLER);
  assign trap_code   = code_q;
  assign trap_epc    = epc_q;
  assign trap_nested = nested_q;
  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign ip_pending  = ip_q;
  assign handler_pc  = VECTOR;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed bench for exc_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
// Interrupt latency follows EXC_INT_SYNC_EN (1 cycle without, 3 with).
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  hw_int, int_mask, int_clr;
  logic        int_en, exl;
  logic        exc_valid, exc_ri, exc_ov, exc_sys, exc_brk;
  logic [31:0] exc_pc, next_pc;
  logic        eret;
  logic        trap_req;
  logic [4:0]  trap_code;
  logic [31:0] trap_epc;
  logic        trap_nested;
  logic        trap_ack;
  logic [5:0]  ip_pending;
  logic        flush, stall, redirect;
  logic [31:0] handler_pc;
  logic        in_handler;

  int tests  = 0;
  int failed = 0;

`ifdef EXC_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hw_int(hw_int), .int_mask(int_mask),
    .int_en(int_en), .exl(exl), .int_clr(int_clr), .exc_valid(exc_valid),
    .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_brk(exc_brk),
    .exc_pc(exc_pc), .next_pc(next_pc), .eret(eret), .trap_req(trap_req),
    .trap_code(trap_code), .trap_epc(trap_epc), .trap_nested(trap_nested),
    .trap_ack(trap_ack), .ip_pending(ip_pending), .flush(flush), .stall(stall),
    .redirect(redirect), .handler_pc(handler_pc), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_exc();
    exc_valid = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0; exc_sys = 1'b0; exc_brk = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hw_int = '0; int_mask = '0; int_clr = '0; int_en = 1'b0; exl = 1'b0;
    exc_valid = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0; exc_sys = 1'b0; exc_brk = 1'b0;
    exc_pc = '0; next_pc = '0; eret = 1'b0; trap_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_trap_req", trap_req, 0);
    chk("rst_code", trap_code, 0);
    chk("rst_epc", trap_epc, 0);
    chk("rst_ip", ip_pending, 0);
    chk("rst_flags", {flush, stall, redirect, in_handler, trap_nested}, 0);
    chk("handler_pc", handler_pc, 32'h0000_3000);
    rst_n = 1'b1;
    tick();
    chk("idle_req", trap_req, 0);

    // Syscall: request one cycle after detection, flush one cycle
    exc_valid = 1'b1; exc_sys = 1'b1; exc_pc = 32'h40;
    tick();
    clr_exc();
    chk("sys_req", trap_req, 1);
    chk("sys_code", trap_code, 8);
    chk("sys_epc", trap_epc, 32'h40);
    chk("sys_flush", flush, 1);
    chk("sys_stall", stall, 1);
    chk("sys_nested", trap_nested, 0);
    tick();
    chk("sys_flush_pulse", flush, 0);
    chk("sys_req_hold", trap_req, 1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("sys_redirect", redirect, 1);
    chk("sys_req_drop", trap_req, 0);
    chk("sys_in_handler", in_handler, 1);
    tick();
    chk("sys_redirect_pulse", redirect, 0);
    chk("sys_in_handler2", in_handler, 1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("sys_eret", in_handler, 0);

    // Interrupt on line 3, then clear while the level is held high
    int_en = 1'b1; exl = 1'b0; int_mask = 6'b001000; next_pc = 32'h100;
    hw_int = 6'b001000;
    for (int i = 0; i < LAT; i++) tick();
    chk("int_pending", ip_pending, 6'b001000);
    chk("int_no_req_yet", trap_req, 0);
    tick();
    chk("int_req", trap_req, 1);
    chk("int_code", trap_code, 0);
    chk("int_epc", trap_epc, 32'h100);
    int_clr = 6'b001000;
    tick();
    int_clr = '0;
    chk("int_clr", ip_pending, 0);
    tick();
    chk("int_clr_stays", ip_pending, 0);
    chk("int_req_hold", trap_req, 1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("eret_in_req_ignored", trap_req, 1);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    exl = 1'b1;
    chk("int_in_handler", in_handler, 1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    exl = 1'b0;
    chk("int_eret", in_handler, 0);

    // RI+Ov with an eligible pending interrupt: RI wins, interrupt taken after eret
    int_mask = 6'b000001; next_pc = 32'h200;
    hw_int = 6'b001001;
    for (int i = 0; i < LAT; i++) tick();
    chk("pri_pending", ip_pending, 6'b000001);
    exc_valid = 1'b1; exc_ri = 1'b1; exc_ov = 1'b1; exc_pc = 32'h80;
    tick();
    clr_exc();
    chk("pri_code", trap_code, 10);
    chk("pri_epc", trap_epc, 32'h80);
    chk("pri_still_pending", ip_pending, 6'b000001);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    exl = 1'b1;
    tick();
    chk("pri_no_int_in_handler", trap_req, 0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    exl = 1'b0;
    chk("pri_eret_idle", in_handler, 0);
    tick();
    chk("pri_int_req", trap_req, 1);
    chk("pri_int_code", trap_code, 0);
    chk("pri_int_epc", trap_epc, 32'h200);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    exl = 1'b1;
    chk("pri_int_handler", in_handler, 1);

    // Nested: Brk together with eret in HANDLER
    exc_valid = 1'b1; exc_brk = 1'b1; exc_pc = 32'h300; eret = 1'b1;
    tick();
    clr_exc();
    eret = 1'b0;
    chk("nest_req", trap_req, 1);
    chk("nest_code", trap_code, 9);
    chk("nest_flag", trap_nested, 1);
    chk("nest_epc", trap_epc, 32'h200);
    chk("nest_not_handler", in_handler, 0);
    tick();
    chk("nest_req_hold", trap_req, 1);
    trap_ack = 1'b1;
    tick();
    chk("nest_redirect", redirect, 1);
    chk("nest_handler", in_handler, 1);
    // ack outside REQ is ignored
    tick();
    trap_ack = 1'b0;
    chk("ack_in_handler_ignored", {redirect, trap_req, in_handler}, 3'b001);

    // Reset in the middle of a request
    int_clr = 6'b000001;
    tick();
    int_clr = '0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    exl = 1'b0; int_en = 1'b0; hw_int = '0;
    exc_valid = 1'b1; exc_ov = 1'b1; exc_pc = 32'h500;
    tick();
    clr_exc();
    chk("ov_req", trap_req, 1);
    chk("ov_code", trap_code, 12);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_flags", {trap_req, flush, stall, redirect, in_handler, trap_nested}, 0);
    chk("midrst_code", trap_code, 0);
    chk("midrst_epc", trap_epc, 0);
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("ack_after_rst_ignored", {trap_req, redirect, in_handler}, 0);

    // Edge-detect latency and set-wins on collision
    hw_int = 6'b000001;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      chk("lat_not_yet", ip_pending, 0);
    end
    tick();
    chk("lat_set", ip_pending, 6'b000001);
    hw_int = 6'b000011;
    for (int i = 0; i < LAT - 1; i++) tick();
    int_clr = 6'b000011;
    tick();
    int_clr = '0;
    chk("set_wins", ip_pending, 6'b000010);
    chk("no_trap_int_disabled", trap_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt initiator for the CP0 block: collects synchronous exceptions from the EX stage and external hardware interrupt lines.
- Prioritises them and issues a single trap request (cause code + EPC) to CP0 over a req/ack handshake.
- Flushes and stalls the pipeline while the request is outstanding, redirects fetch to the handler vector, then tracks the in-handler state until `eret`.

Parameters:
- VECTOR, 32'h0000_3000, handler entry address driven on handler_pc.
- INT_LINES, 6, number of hardware interrupt lines (fixed at 6; matches Cause.IP[7:2]).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- hw_int  in  6  external interrupt lines, level, active-high
- int_mask  in  6  Status.IM[7:2] from CP0
- int_en  in  1  Status.IE from CP0
- exl  in  1  Status.EXL from CP0
- int_clr  in  6  one-cycle pulses clearing pending bits (mtc0 to Cause)
- exc_valid  in  1  EX-stage instruction valid
- exc_ri, exc_ov, exc_sys, exc_brk  in  1 each  EX-stage exception flags, qualified by exc_valid
- exc_pc  in  32  PC of the EX-stage instruction
- next_pc  in  32  resume address used for interrupts
- eret  in  1  one-cycle pulse, eret executed
- trap_req  out  1  request to CP0
- trap_code  out  5  ExcCode: 0 Int, 8 Sys, 9 Bp, 10 RI, 12 Ov
- trap_epc  out  32  EPC to record
- trap_nested  out  1  trap raised while in handler; CP0 must not overwrite EPC
- trap_ack  in  1  CP0 accepted the request
- ip_pending  out  6  pending interrupt bits for Cause.IP
- flush  out  1  one-cycle pulse, kill IF/ID/EX
- stall  out  1  hold the PC while a request is outstanding
- redirect  out  1  one-cycle pulse, load handler_pc into the PC
- handler_pc  out  32  constant VECTOR
- in_handler  out  1  high from ack until eret

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; trap_req, flush, stall, redirect, in_handler, trap_nested all 0; trap_code 0; trap_epc 0; ip_pending 0; edge history 0. Reset mid-request drops trap_req at that edge, with no ack required.
- Interrupt edge capture:
  - ip_pending[i] sets on a rising edge of hw_int[i], i.e. the previous registered sample is 0 and the current sample is 1.
  - ip_pending[i] clears on int_clr[i].
  - Set and clear in the same cycle: set wins.
  - A level held high does not re-set a pending bit after it is cleared.
- Synchronous exception present = exc_valid & (ri|ov|sys|brk). Priority among them: RI > Ov > Sys > Brk. Each is stored with EPC = exc_pc.
- Interrupt eligible = int_en & ~exl & |(ip_pending & int_mask). It is stored with code 0 and EPC = next_pc.
- A synchronous exception beats an interrupt in the same cycle.
- FSM: IDLE, REQ, HANDLER.
  - IDLE: on a synchronous exception or eligible interrupt, latch trap_code/trap_epc, set trap_nested=0, and go to REQ. flush pulses high for the one cycle following detection, which is the first REQ cycle.
  - REQ: trap_req=1 and stall=1. trap_code, trap_epc and trap_nested are held stable until trap_ack; new events are ignored. On trap_ack: trap_req=0 next cycle, redirect pulses for one cycle, go to HANDLER. Ack arriving in the first REQ cycle is legal.
  - HANDLER: in_handler=1.
    - A synchronous exception goes to REQ with trap_nested=1, new code, and trap_epc unchanged.
    - Interrupts are not taken, because exl is 1.
    - eret goes to IDLE.
    - eret together with a synchronous exception in the same cycle: the exception wins and the eret is dropped.
- eret in IDLE or REQ: ignored.
- Trap latency: detection edge to trap_req high = 1 cycle. Ack to redirect = 1 cycle.
- trap_ack while not in REQ: ignored.

Optional Feature:
- Macro: EXC_INT_SYNC_EN.
- When defined: hw_int passes through a 2-flop synchronizer (reset to 0) before edge detection, adding 2 cycles of interrupt latency.
- When undefined: hw_int is sampled directly, so the edge is seen one cycle after the rising edge. hw_int must then be synchronous to clk.

Test Plan:
- exc_valid=1, exc_sys=1, exc_pc=32'h0000_0040 in IDLE → next cycle trap_req=1, trap_code=8, trap_epc=0x40, flush=1 for 1 cycle; ack 2 cycles later → redirect=1 for 1 cycle, handler_pc=0x3000, in_handler=1.
- exc_ri=1 and exc_ov=1 together with ip_pending[0]=1 eligible → trap_code=10; the interrupt stays pending and is taken after eret once exl=0.
- hw_int[3] rises, int_mask[3]=1, int_en=1, exl=0, next_pc=32'h0000_0100 → ip_pending=6'b001000, trap_code=0, trap_epc=0x100; hold hw_int high and pulse int_clr[3] → ip_pending[3]=0 and stays 0.
- In HANDLER: exc_brk=1 and eret in the same cycle → REQ with trap_code=9, trap_nested=1, trap_epc unchanged; the eret is dropped.
- rst_n=0 while in REQ with trap_req=1 → next edge: all outputs 0, state IDLE; a later trap_ack is ignored.
- With EXC_INT_SYNC_EN defined: hw_int[0] rise → ip_pending[0] sets 3 cycles later (1 cycle later without the macro).
